// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod: the master drives the controls
// and the slave (the counter) returns the count and the status flags.
interface counter_updown_mod_if #(
   parameter int unsigned WIDTH = 4
);
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic             enable;
   logic             up_down;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             limit_seen;

   modport master (
      output clear, load, load_data, enable, up_down,
      input  count, tc, wrap, limit_seen
   );

   modport slave (
      input  clear, load, load_data, enable, up_down,
      output count, tc, wrap, limit_seen
   );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down counter with clamped parallel load, synchronous clear, programmable
// modulus, wrap-or-saturate limits, terminal-count strobe and limit flags.
module counter_updown_mod #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MOD_MAX  = 2**WIDTH - 1,
   parameter int unsigned SATURATE = 0
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   counter_updown_mod_if.slave  bus_if
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD_MAX);
   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             limit_seen_q;
   logic             limit_seen_d;
   logic             limit_cond;
   logic             limit_evt;

   // Loads above the modulus are clamped so count never exceeds MOD_MAX.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
      return (d > MAX_C) ? MAX_C : d;
   endfunction

   function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur,
                                                     input logic            up);
      logic [WIDTH-1:0] nxt;
      if (up) begin
         if (cur == MAX_C) nxt = (SATURATE != 0) ? cur : '0;
         else              nxt = cur + ONE_C;
      end else begin
         if (cur == '0)    nxt = (SATURATE != 0) ? cur : MAX_C;
         else              nxt = cur - ONE_C;
      end
      return nxt;
   endfunction

   assign limit_cond = bus_if.up_down ? (count_q == MAX_C) : (count_q == '0);
   assign limit_evt  = bus_if.enable & ~bus_if.load & ~bus_if.clear & limit_cond;

   always_comb begin
      count_d      = count_q;
      wrap_d       = 1'b0;
      limit_seen_d = limit_seen_q;
      if (bus_if.clear) begin
         count_d      = '0;
         limit_seen_d = 1'b0;
      end else if (bus_if.load) begin
         count_d = clamp_load(bus_if.load_data);
      end else if (bus_if.enable) begin
         count_d = step_count(count_q, bus_if.up_down);
         wrap_d  = limit_evt;
         if (limit_evt) limit_seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_q      <= '0;
         wrap_q       <= 1'b0;
         limit_seen_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         wrap_q       <= wrap_d;
         limit_seen_q <= limit_seen_d;
      end
   end

   // tc is deliberately not gated by load/clear so it flags the limit state itself.
   assign bus_if.count      = count_q;
   assign bus_if.tc         = bus_if.enable & limit_cond;
   assign bus_if.wrap       = wrap_q;
   assign bus_if.limit_seen = limit_seen_q;

endmodule
